memory: RTL and testbench
=========================

// Module: memory
// PURPOSE
//  Byte-addressable 256 x 8 data/instruction memory for the 16-bit processor.
//  - Byte writes; 16-bit little-endian word reads ({mem[a+1], mem[a]}).
//  - Synchronous write, registered read; sits between the core's memory-address
//    stage and its data bus.
// PARAMETERS
//  ADDR_W  8   address width; depth = 2**ADDR_W bytes
//  BYTE_W  8   stored byte / write-data width
//  WORD_W  16  read-data width; must equal 2*BYTE_W
// PORTS
//  clk       in   1       single clock, all state updates on rising edge
//  rst       in   1       reset, synchronous and active-high
//  maddr     in   ADDR_W  byte address for read and write
//  mrd       in   1       read enable
//  mwr       in   1       write enable
//  mwr_data  in   BYTE_W  byte to write at maddr
//  data      out  WORD_W  registered read word
// BEHAVIOUR
//  - Reset (rst=1 at posedge):
//    - all 256 bytes cleared to 8'h00; data <= 16'h0000.
//    - rst has priority over mrd/mwr in the same cycle.
//  - Write: posedge with mwr=1, rst=0 -> mem[maddr] <= mwr_data. One byte only.
//  - Read: posedge with mrd=1, rst=0 -> data <= {mem[maddr+1], mem[maddr]}.
//    - Latency 1 cycle; visible after the edge that sampled mrd.
//  - Read address wrap: maddr+1 computed mod 256; maddr=8'hFF reads
//    {mem[8'h00], mem[8'hFF]}.
//  - mrd=0: data holds its last value (no tri-state, no clear).
//  - mrd=1 and mwr=1 in the same cycle: write performed; read returns the
//    pre-write contents (read-before-write) for both bytes, including when
//    maddr+1 is the written byte.
//  - Write and read do not interact when neither enable is set.
//    Back-to-back accesses need no idle cycle.
//  - Unknown (X/Z) mwr/mrd is not a legal input; behaviour is undefined.
//  - No handshake or ready: every access completes in one cycle.
// STRUCTURE
//  - Shared package (proc_pkg): ADDR_W, BYTE_W, WORD_W, and MEM_DEPTH = 256.
//  - Single module; storage as reg [BYTE_W-1:0] mem[0:MEM_DEPTH-1].
//  - Reset clear done with a for-loop in the clocked block.
//  - No sub-module.
// TESTING
//  1. Reset: rst=1 one cycle, then mrd=1, maddr=8'h00/8'h7F/8'hFF
//     -> data=16'h0000 each read.
//  2. Write 8'h00@8'h00 and 8'h01@8'h01, then mrd at 8'h01 -> data=16'h0001;
//     mrd at 8'h00 -> data=16'h0100.
//  3. Wrap: write 8'hAA@8'hFF, 8'h55@8'h00; read 8'hFF -> data=16'h55AA.
//  4. Simultaneous: mem[8'h10]=8'h11, mem[8'h11]=8'h22; mrd=mwr=1, maddr=8'h10,
//     mwr_data=8'h99 -> data=16'h2211.
//     Next read of 8'h10 -> data=16'h2299.
//  5. Hold: after a read giving 16'h2299, drop mrd and write 8'h00@8'h10
//     -> data stays 16'h2299.
//  6. Reset mid-operation: rst=1 with mwr=1 at 8'h20 (mwr_data=8'h77) and mrd=1
//     -> data=16'h0000. Later read of 8'h20 -> data=16'h0000.

Source files
------------

// File: rtl/memory_pkg.sv
// Shared widths and depth for the 16-bit processor's byte-addressable memory.
// Word reads are little-endian pairs of stored bytes.
package memory_pkg;

    localparam int unsigned ADDR_W    = 8;
    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned WORD_W    = 16;
    localparam int unsigned MEM_DEPTH = 256;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [BYTE_W-1:0] byte_t;
    typedef logic [WORD_W-1:0] word_t;

    // Little-endian word from the byte at a and the byte at a+1.
    function automatic word_t pack_word(input byte_t lo, input byte_t hi);
        return {hi, lo};
    endfunction

endpackage

// File: rtl/memory_if.sv
// Core-to-memory bus: byte address, read/write enables, write byte and read word.
// The core drives the master side; the memory is the slave.
interface memory_if;
    import memory_pkg::*;

    addr_t maddr;
    logic  mrd;
    logic  mwr;
    byte_t mwr_data;
    word_t data;

    modport master (
        output maddr,
        output mrd,
        output mwr,
        output mwr_data,
        input  data
    );

    modport slave (
        input  maddr,
        input  mrd,
        input  mwr,
        input  mwr_data,
        output data
    );

endinterface

// File: rtl/memory.sv
// 256 x 8 byte-write memory with registered 16-bit little-endian word reads.
// Read address wraps mod 256; a read and write in the same cycle read the old bytes.
module memory
    import memory_pkg::*;
(
    input logic      clk,
    input logic      rst,
    memory_if.slave  bus
);

    byte_t r_mem [0:MEM_DEPTH-1];
    word_t r_data;
    addr_t w_addr_hi;

    // Natural width truncation gives the mod-256 wrap for the upper byte.
    assign w_addr_hi = bus.maddr + addr_t'(1);
    assign bus.data  = r_data;

    // The read samples r_mem before the write's non-blocking update lands,
    // which yields read-before-write for both bytes of the word.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < MEM_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_data <= '0;
        end else begin
            if (bus.mwr) begin
                r_mem[bus.maddr] <= bus.mwr_data;
            end
            if (bus.mrd) begin
                r_data <= pack_word(r_mem[bus.maddr], r_mem[w_addr_hi]);
            end
        end
    end

endmodule

// File: tb/tb_memory.sv
// Directed testbench for memory: reset, byte writes, word reads, wrap,
// read-before-write, hold and reset priority, with hand-computed expectations.
module tb_memory;
    import memory_pkg::*;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    memory_if bus ();

    memory u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input word_t obs, input word_t exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock edge; inputs change and outputs are sampled 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst          = 1'b0;
        bus.mrd      = 1'b0;
        bus.mwr      = 1'b0;
        bus.maddr    = '0;
        bus.mwr_data = '0;
    endtask

    task automatic wr(input addr_t a, input byte_t d);
        idle();
        bus.mwr      = 1'b1;
        bus.maddr    = a;
        bus.mwr_data = d;
        tick();
    endtask

    task automatic rd(input addr_t a);
        idle();
        bus.mrd   = 1'b1;
        bus.maddr = a;
        tick();
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        idle();
        #2;

        // Reset clears storage and the output word.
        rst = 1'b1;
        tick();
        check("reset_data", bus.data, 16'h0000);
        rd(8'h00); check("rst_rd_00", bus.data, 16'h0000);
        rd(8'h7F); check("rst_rd_7F", bus.data, 16'h0000);
        rd(8'hFF); check("rst_rd_FF", bus.data, 16'h0000);

        // Little-endian pairing, back-to-back writes then reads.
        wr(8'h00, 8'h00);
        wr(8'h01, 8'h01);
        rd(8'h01); check("le_rd_01", bus.data, 16'h0001);
        rd(8'h00); check("le_rd_00", bus.data, 16'h0100);

        // Upper byte address wraps to 8'h00.
        wr(8'hFF, 8'hAA);
        wr(8'h00, 8'h55);
        rd(8'hFF); check("wrap_rd_FF", bus.data, 16'h55AA);
        rd(8'h00); check("wrap_rd_00", bus.data, 16'h0155);

        // Simultaneous read and write returns pre-write bytes.
        wr(8'h10, 8'h11);
        wr(8'h11, 8'h22);
        idle();
        bus.mrd      = 1'b1;
        bus.mwr      = 1'b1;
        bus.maddr    = 8'h10;
        bus.mwr_data = 8'h99;
        tick();
        check("rbw_old", bus.data, 16'h2211);
        rd(8'h10); check("rbw_new", bus.data, 16'h2299);

        // mrd low: output holds through a write and an idle cycle.
        wr(8'h10, 8'h00);
        check("hold_wr", bus.data, 16'h2299);
        idle();
        tick();
        check("hold_idle", bus.data, 16'h2299);
        rd(8'h10); check("hold_after", bus.data, 16'h2200);

        // Reset wins over a simultaneous write and read.
        idle();
        rst          = 1'b1;
        bus.mrd      = 1'b1;
        bus.mwr      = 1'b1;
        bus.maddr    = 8'h20;
        bus.mwr_data = 8'h77;
        tick();
        check("rst_prio_data", bus.data, 16'h0000);
        rd(8'h20); check("rst_prio_rd_20", bus.data, 16'h0000);
        rd(8'h10); check("rst_clr_10", bus.data, 16'h0000);
        rd(8'hFF); check("rst_clr_FF", bus.data, 16'h0000);

        // Write after reset-priority cycle still works normally.
        wr(8'h21, 8'hC3);
        rd(8'h20); check("post_rst_rd_20", bus.data, 16'hC300);

        idle();
        tick();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
